// File: rtl/exe_mem_reg_if.sv
// EXE->MEM pipeline register bundle: EXE-side inputs plus the registered stage outputs.
// master drives the EXE side and observes the stage; slave is the pipeline register itself.
interface exe_mem_reg_if #(
  parameter int CNT_W = 16
);
  logic             freeze;
  logic             flush;
  logic             valid_in;
  logic             wb_en_in;
  logic             mem_r_en_in;
  logic             mem_w_en_in;
  logic             s_in;
  logic [31:0]      alu_res_in;
  logic [3:0]       status_in;
  logic [31:0]      val_rm_in;
  logic [3:0]       dest_in;

  logic             valid;
  logic             wb_en;
  logic             mem_r_en;
  logic             mem_w_en;
  logic [31:0]      alu_res;
  logic [31:0]      val_rm;
  logic [3:0]       dest;
  logic [3:0]       status;
  logic             carry;
  logic [CNT_W-1:0] inst_count;

  modport master (
    output freeze, flush, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, s_in,
           alu_res_in, status_in, val_rm_in, dest_in,
    input  valid, wb_en, mem_r_en, mem_w_en, alu_res, val_rm, dest, status,
           carry, inst_count
  );

  modport slave (
    input  freeze, flush, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, s_in,
           alu_res_in, status_in, val_rm_in, dest_in,
    output valid, wb_en, mem_r_en, mem_w_en, alu_res, val_rm, dest, status,
           carry, inst_count
  );
endinterface

// File: rtl/exe_mem_reg.sv
// EXE/MEM pipeline register with NZCV flag register and retired-instruction counter; 1-cycle latency.
// Optional macro STATUS_BYPASS_EN forwards status_in to status/carry in the cycle it is being written.
module exe_mem_reg #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  exe_mem_reg_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_res;
    logic [31:0] val_rm;
    logic [3:0]  dest;
  } stage_t;

  stage_t           stage_q, stage_d;
  logic [3:0]       status_q, status_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             status_upd;

  // Priority below reset: freeze holds everything, flush squashes the stage only.
  always_comb begin
    stage_d    = stage_q;
    status_d   = status_q;
    cnt_d      = cnt_q;
    status_upd = 1'b0;
    if (!bus.freeze) begin
      if (bus.flush) begin
        stage_d = '0;
      end else begin
        stage_d.valid    = bus.valid_in;
        stage_d.wb_en    = bus.valid_in & bus.wb_en_in;
        stage_d.mem_r_en = bus.valid_in & bus.mem_r_en_in;
        stage_d.mem_w_en = bus.valid_in & bus.mem_w_en_in;
        stage_d.alu_res  = bus.alu_res_in;
        stage_d.val_rm   = bus.val_rm_in;
        stage_d.dest     = bus.dest_in;
        if (bus.valid_in) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (bus.valid_in && bus.s_in && !rst) begin
          status_upd = 1'b1;
          status_d   = bus.status_in;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q  <= '0;
      status_q <= '0;
      cnt_q    <= '0;
    end else begin
      stage_q  <= stage_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.valid      = stage_q.valid;
  assign bus.wb_en      = stage_q.wb_en;
  assign bus.mem_r_en   = stage_q.mem_r_en;
  assign bus.mem_w_en   = stage_q.mem_w_en;
  assign bus.alu_res    = stage_q.alu_res;
  assign bus.val_rm     = stage_q.val_rm;
  assign bus.dest       = stage_q.dest;
  assign bus.inst_count = cnt_q;

`ifdef STATUS_BYPASS_EN
  // Same-cycle forwarding so the condition check sees flags from the instruction being retired.
  assign bus.status = status_upd ? bus.status_in : status_q;
`else
  logic unused_upd;
  assign unused_upd = status_upd;
  assign bus.status = status_q;
`endif
  assign bus.carry = bus.status[1];

endmodule

// File: tb/tb_exe_mem_reg.sv
// Scoreboard bench for exe_mem_reg: a reference model pushes expected stage state per cycle,
// popped and compared one clock later; flags are also compared just before each edge.
module tb_exe_mem_reg;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_mem_reg_if #(.CNT_W(CNT_W)) bus ();
  exe_mem_reg #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic             v, wb, mr, mw;
    logic [31:0]      alu, rm;
    logic [3:0]       dest, status;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   m_known  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input logic r, input logic fz, input logic fl, input logic vi,
                     input logic wb, input logic mr, input logic mw, input logic s,
                     input logic [31:0] alu, input logic [31:0] rm,
                     input logic [3:0] st, input logic [3:0] d);
    exp_t e;
    logic [3:0] es;
    rst = r;
    bus.freeze = fz;   bus.flush = fl;      bus.valid_in = vi;
    bus.wb_en_in = wb; bus.mem_r_en_in = mr; bus.mem_w_en_in = mw;
    bus.s_in = s;      bus.alu_res_in = alu; bus.val_rm_in = rm;
    bus.status_in = st; bus.dest_in = d;
    @(negedge clk);
    if (m_known) begin
      es = m.status;
`ifdef STATUS_BYPASS_EN
      if (!r && !fz && !fl && vi && s) es = st;
`endif
      check("status_pre", 32'(bus.status), 32'(es));
      check("carry_pre", 32'(bus.carry), 32'(es[1]));
    end
    if (r) begin
      m = '{default: '0};
      m_known = 1'b1;
    end else if (!fz) begin
      if (fl) begin
        m.v = 0; m.wb = 0; m.mr = 0; m.mw = 0;
        m.alu = 0; m.rm = 0; m.dest = 0;
      end else begin
        m.v = vi; m.wb = vi & wb; m.mr = vi & mr; m.mw = vi & mw;
        m.alu = alu; m.rm = rm; m.dest = d;
        if (vi && s) m.status = st;
        if (vi) m.cnt = m.cnt + CNT_W'(1);
      end
    end
    if (m_known) sb.push_back(m);
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("valid", 32'(bus.valid), 32'(e.v));
      check("wb_en", 32'(bus.wb_en), 32'(e.wb));
      check("mem_r_en", 32'(bus.mem_r_en), 32'(e.mr));
      check("mem_w_en", 32'(bus.mem_w_en), 32'(e.mw));
      check("alu_res", bus.alu_res, e.alu);
      check("val_rm", bus.val_rm, e.rm);
      check("dest", 32'(bus.dest), 32'(e.dest));
      check("status", 32'(bus.status), 32'(e.status));
      check("carry", 32'(bus.carry), 32'(e.status[1]));
      check("inst_count", 32'(bus.inst_count), 32'(e.cnt));
    end
  endtask

  task automatic rnd_cyc(input logic r, input logic fz, input logic fl);
    cyc(r, fz, fl, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
        $urandom, $urandom, 4'($urandom), 4'($urandom));
  endtask

  initial begin
    rst = 1'b0;
    // Reset with every input driven nonzero
    cyc(1, 1, 1, 1, 1, 1, 1, 1, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 4'hF, 4'hF);
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 32'h0000_1234, 32'h0, 4'h0, 4'd5);
    check("load_count_is_1", 32'(bus.inst_count), 32'd1);
    // Flag update then a non-updating instruction
    cyc(0, 0, 0, 1, 0, 0, 0, 1, 32'h1, 32'h2, 4'b0110, 4'd1);
    check("flags_0110", 32'(bus.status), 32'h6);
    cyc(0, 0, 0, 1, 0, 1, 0, 0, 32'h3, 32'h4, 4'b1001, 4'd2);
    // Freeze beats flush for three cycles, then flush alone
    for (int i = 0; i < 3; i++) rnd_cyc(0, 1, 1);
    rnd_cyc(0, 0, 1);
    // Bubble with stray control bits and s_in
    cyc(0, 0, 0, 0, 1, 1, 1, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'b1111, 4'd3);
    // Reset during a held instruction, then recovery load
    cyc(0, 0, 0, 1, 1, 1, 1, 1, 32'h55, 32'h66, 4'b1010, 4'd7);
    cyc(1, 1, 0, 1, 1, 1, 1, 1, 32'h77, 32'h88, 4'b0101, 4'd8);
    cyc(0, 0, 0, 1, 0, 1, 0, 0, 32'h99, 32'hAA, 4'h0, 4'd9);
    // Counter wrap: reset then 16 valid loads -> 1..15, 0
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 4'h0);
    for (int i = 0; i < 16; i++)
      cyc(0, 0, 0, 1, 1, 0, 0, 0, 32'(i), 32'(i * 3), 4'h0, 4'(i));
    check("count_wrapped", 32'(bus.inst_count), 32'd0);
    // Mixed random traffic
    for (int i = 0; i < 60; i++)
      rnd_cyc(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 4) == 0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
